// File: rtl/johnson_pkg.sv
// rtl/johnson_pkg.sv - shared Johnson-code state encoding and legality/index helpers
package johnson_pkg;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_TRACK  = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  // Legal codes are a run of ones anchored at the MSB or at the LSB (covers all-0 and all-1).
  function automatic logic johnson_is_legal(input logic [31:0] code, input int width);
    logic [32:0] lsb_run;
    logic [32:0] msb_run;
    logic [32:0] c;
    logic        ok;
    ok = 1'b0;
    c  = {1'b0, code};
    for (int k = 0; k <= width; k++) begin
      lsb_run = (33'd1 << k) - 33'd1;
      msb_run = lsb_run << (width - k);
      if ((c == lsb_run) || (c == msb_run)) ok = 1'b1;
    end
    return ok;
  endfunction

  function automatic int johnson_index(input logic [31:0] code, input int width);
    int pop;
    pop = 0;
    for (int b = 0; b < width; b++) pop += int'({31'b0, code[b]});
    if (code[width-1] || (code == 32'd0)) return pop;
    return 2 * width - pop;
  endfunction

endpackage

// File: rtl/johnson_decode.sv
// rtl/johnson_decode.sv - combinational Johnson code to {legal, phase index} decoder
module johnson_decode
  import johnson_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0]          i_code,
  output logic                      o_legal,
  output logic [$clog2(2*WIDTH)-1:0] o_idx
);

  localparam int IW = $clog2(2*WIDTH);

  logic [31:0] w_code_ext;

  assign w_code_ext = {{(32-WIDTH){1'b0}}, i_code};
  assign o_legal    = johnson_is_legal(w_code_ext, WIDTH);
  assign o_idx      = IW'(johnson_index(w_code_ext, WIDTH));

endmodule

// File: rtl/johnson_seq_checker.sv
// rtl/johnson_seq_checker.sv - Johnson sequence monitor: decode, lock FSM, saturating error count
module johnson_seq_checker
  import johnson_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int LOCK_COUNT = 3,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                        clk,
  input  logic                        clear,
  input  logic [WIDTH-1:0]            code_in,
  input  logic                        code_valid,
  output logic [$clog2(2*WIDTH)-1:0]  index,
  output logic                        index_valid,
  output logic                        code_legal,
  output logic                        locked,
  output logic                        seq_err,
  output logic [ERR_CNT_W-1:0]        err_count
);

  localparam int IW = $clog2(2*WIDTH);
  localparam int RW = $clog2(LOCK_COUNT+1);
  localparam logic [IW-1:0] LAST_IDX = IW'(2*WIDTH-1);
  localparam logic [RW-1:0] LOCK_RUN = RW'(LOCK_COUNT);

  state_t                r_state;
  state_t                w_next_state;
  logic [IW-1:0]         r_prev;
  logic [IW-1:0]         w_next_prev;
  logic [IW-1:0]         w_expected;
  logic [IW-1:0]         w_idx;
  logic [IW-1:0]         r_index;
  logic [RW-1:0]         r_run;
  logic [RW-1:0]         w_next_run;
  logic [RW-1:0]         w_run_inc;
  logic                  w_legal;
  logic                  w_seq_err;
  logic                  r_index_valid;
  logic                  r_code_legal;
  logic                  r_seq_err;
  logic [ERR_CNT_W-1:0]  r_err_count;

  johnson_decode #(.WIDTH(WIDTH)) u_decode (
    .i_code  (code_in),
    .o_legal (w_legal),
    .o_idx   (w_idx)
  );

  // Sequence length need not be a power of two, so wrap explicitly.
  assign w_expected = (r_prev == LAST_IDX) ? '0 : r_prev + 1'b1;
  assign w_run_inc  = r_run + 1'b1;

  always_ff @(posedge clk or posedge clear) begin
    if (clear) r_state <= ST_HUNT;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_next_prev  = r_prev;
    w_next_run   = r_run;
    w_seq_err    = 1'b0;
    if (code_valid) begin
      case (r_state)
        ST_HUNT: begin
          if (w_legal) begin
            w_next_prev  = w_idx;
            w_next_run   = '0;
            w_next_state = ST_TRACK;
          end
        end
        ST_TRACK: begin
          if (!w_legal) begin
            w_next_state = ST_HUNT;
          end else begin
            w_next_prev = w_idx;
            if (w_idx == w_expected) begin
              w_next_run = w_run_inc;
              if (w_run_inc == LOCK_RUN) w_next_state = ST_LOCKED;
            end else begin
              w_next_run = '0;
            end
          end
        end
        ST_LOCKED: begin
          if (!w_legal) begin
            w_seq_err    = 1'b1;
            w_next_state = ST_HUNT;
          end else if (w_idx != w_expected) begin
            w_seq_err    = 1'b1;
            w_next_prev  = w_idx;
            w_next_run   = '0;
            w_next_state = ST_TRACK;
          end else begin
            w_next_prev = w_idx;
          end
        end
        default: w_next_state = ST_HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      r_prev        <= '0;
      r_run         <= '0;
      r_index       <= '0;
      r_index_valid <= 1'b0;
      r_code_legal  <= 1'b0;
      r_seq_err     <= 1'b0;
      r_err_count   <= '0;
    end else begin
      r_prev        <= w_next_prev;
      r_run         <= w_next_run;
      r_index_valid <= code_valid && w_legal;
      r_seq_err     <= w_seq_err;
      if (code_valid) r_code_legal <= w_legal;
      if (code_valid && w_legal) r_index <= w_idx;
      if (w_seq_err && (r_err_count != {ERR_CNT_W{1'b1}})) r_err_count <= r_err_count + 1'b1;
    end
  end

  assign index       = r_index;
  assign index_valid = r_index_valid;
  assign code_legal  = r_code_legal;
  assign locked      = (r_state == ST_LOCKED);
  assign seq_err     = r_seq_err;
  assign err_count   = r_err_count;

endmodule

// File: tb/tb_johnson_seq_checker.sv
// tb/tb_johnson_seq_checker.sv - directed self-checking bench for johnson_seq_checker
module tb_johnson_seq_checker;

  logic       clk;
  logic       clear;
  logic [3:0] code_in;
  logic       code_valid;
  logic [2:0] index,  index2;
  logic       index_valid, index_valid2;
  logic       code_legal, code_legal2;
  logic       locked, locked2;
  logic       seq_err, seq_err2;
  logic [7:0] err_count;
  logic [1:0] err_count2;

  int errors = 0;
  int checks = 0;

  logic [3:0] seq [8] = '{4'b0000, 4'b1000, 4'b1100, 4'b1110, 4'b1111, 4'b0111, 4'b0011, 4'b0001};

  johnson_seq_checker #(.WIDTH(4), .LOCK_COUNT(3), .ERR_CNT_W(8)) dut (
    .clk(clk), .clear(clear), .code_in(code_in), .code_valid(code_valid),
    .index(index), .index_valid(index_valid), .code_legal(code_legal),
    .locked(locked), .seq_err(seq_err), .err_count(err_count)
  );

  johnson_seq_checker #(.WIDTH(4), .LOCK_COUNT(3), .ERR_CNT_W(2)) dut2 (
    .clk(clk), .clear(clear), .code_in(code_in), .code_valid(code_valid),
    .index(index2), .index_valid(index_valid2), .code_legal(code_legal2),
    .locked(locked2), .seq_err(seq_err2), .err_count(err_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input int idx, input bit iv, input bit cl,
                            input bit lk, input bit se, input int ec, input int ec2);
    chk({tag, ".index"},       {29'b0, index},       idx);
    chk({tag, ".index_valid"}, {31'b0, index_valid}, {31'b0, iv});
    chk({tag, ".code_legal"},  {31'b0, code_legal},  {31'b0, cl});
    chk({tag, ".locked"},      {31'b0, locked},      {31'b0, lk});
    chk({tag, ".seq_err"},     {31'b0, seq_err},     {31'b0, se});
    chk({tag, ".err_count"},   {24'b0, err_count},   ec);
    chk({tag, ".err_count2"},  {30'b0, err_count2},  ec2);
    chk({tag, ".locked2"},     {31'b0, locked2},     {31'b0, lk});
  endtask

  task automatic sample(input logic [3:0] c, input logic v);
    code_in    = c;
    code_valid = v;
    @(posedge clk);
    #1;
  endtask

  initial begin
    clear      = 1'b1;
    code_in    = 4'b0000;
    code_valid = 1'b0;
    #2;
    expect_out("reset", 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    clear = 1'b0;

    // Illegal while hunting: flagged, but no error pulse.
    sample(4'b0101, 1'b1);
    expect_out("hunt_illegal", 0, 0, 0, 0, 0, 0, 0);

    // Test 1: two full rotations, lock after the 4th sample.
    for (int k = 0; k < 16; k++) begin
      sample(seq[k % 8], 1'b1);
      expect_out($sformatf("t1_s%0d", k), k % 8, 1, 1, (k >= 3), 0, 0, 0);
    end

    // Test 2: illegal code while locked, then relock in 4 legal samples.
    sample(4'b0101, 1'b1);
    expect_out("t2_err", 7, 0, 0, 0, 1, 1, 1);
    for (int k = 0; k < 4; k++) begin
      sample(seq[k], 1'b1);
      expect_out($sformatf("t2_relock%0d", k), k, 1, 1, (k == 3), 0, 1, 1);
    end

    // Test 3: advance to index 0, then skip 1 -> 3.
    for (int k = 4; k < 9; k++) begin
      sample(seq[k % 8], 1'b1);
      expect_out($sformatf("t3_pre%0d", k), k % 8, 1, 1, 1, 0, 1, 1);
    end
    sample(4'b1000, 1'b1);
    expect_out("t3_1000", 1, 1, 1, 1, 0, 1, 1);
    sample(4'b1110, 1'b1);
    expect_out("t3_skip", 3, 1, 1, 0, 1, 2, 2);
    sample(4'b1111, 1'b1);
    expect_out("t3_1111", 4, 1, 1, 0, 0, 2, 2);
    sample(4'b0111, 1'b1);
    expect_out("t3_0111", 5, 1, 1, 0, 0, 2, 2);
    sample(4'b0011, 1'b1);
    expect_out("t3_0011", 6, 1, 1, 1, 0, 2, 2);

    // Test 4: park at index 2, then idle with garbage on the bus.
    for (int k = 7; k < 11; k++) begin
      sample(seq[k % 8], 1'b1);
      expect_out($sformatf("t4_pre%0d", k), k % 8, 1, 1, 1, 0, 2, 2);
    end
    for (int k = 0; k < 5; k++) begin
      sample(4'b0101, 1'b0);
      expect_out($sformatf("t4_idle%0d", k), 2, 0, 1, 1, 0, 2, 2);
    end
    sample(4'b1110, 1'b1);
    expect_out("t4_resume", 3, 1, 1, 1, 0, 2, 2);

    // Test 5: five errors with relock in between; narrow counter saturates at 3.
    for (int e = 0; e < 5; e++) begin
      sample(4'b0101, 1'b1);
      expect_out($sformatf("t5_err%0d", e), (e == 0) ? 3 : 7, 0, 0, 0, 1, 3 + e, 3);
      for (int k = 4; k < 8; k++) begin
        sample(seq[k], 1'b1);
        expect_out($sformatf("t5_e%0d_r%0d", e, k), k, 1, 1, (k == 7), 0, 3 + e, 3);
      end
    end

    // Test 6: clear between edges takes effect immediately.
    #3;
    clear = 1'b1;
    #1;
    expect_out("t6_clear", 0, 0, 0, 0, 0, 0, 0);
    #2;
    clear = 1'b0;
    for (int k = 1; k < 5; k++) begin
      sample(seq[k], 1'b1);
      expect_out($sformatf("t6_relock%0d", k), k, 1, 1, (k == 4), 0, 0, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
